// File: rtl/riscv_pkg.sv
// Shared constants, types and decode helper for the ALU issue stage.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int SEL_W    = 4;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // bit3 = subtract, bits[2:0] = ALU op (000 SUM, 110 OR, 111 AND)
    localparam logic [SEL_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [SEL_W-1:0] ALU_SUB = 4'b1000;
    localparam logic [SEL_W-1:0] ALU_OR  = 4'b0110;
    localparam logic [SEL_W-1:0] ALU_AND = 4'b0111;

    typedef enum logic {ST_EMPTY, ST_FULL} ostate_t;

    typedef struct packed {
        logic             legal;
        logic             is_r;   // rs2 is a register operand (and a hazard source)
        logic [SEL_W-1:0] sel;
    } dec_t;

    // Maps an instruction word onto an ALU select; anything unsupported is flagged illegal.
    function automatic dec_t decode_instr(input logic [31:0] i);
        dec_t d;
        d.legal = 1'b0;
        d.is_r  = 1'b0;
        d.sel   = ALU_ADD;
        case (i[6:0])
            OP_R: begin
                d.is_r = 1'b1;
                if (i[31:25] == 7'b0000000) begin
                    case (i[14:12])
                        3'b000:  begin d.legal = 1'b1; d.sel = ALU_ADD; end
                        3'b110:  begin d.legal = 1'b1; d.sel = ALU_OR;  end
                        3'b111:  begin d.legal = 1'b1; d.sel = ALU_AND; end
                        default: d.legal = 1'b0;
                    endcase
                end else if (i[31:25] == 7'b0100000 && i[14:12] == 3'b000) begin
                    d.legal = 1'b1;
                    d.sel   = ALU_SUB;
                end
            end
            OP_I: begin
                case (i[14:12])
                    3'b000:  begin d.legal = 1'b1; d.sel = ALU_ADD; end
                    3'b110:  begin d.legal = 1'b1; d.sel = ALU_OR;  end
                    3'b111:  begin d.legal = 1'b1; d.sel = ALU_AND; end
                    default: d.legal = 1'b0;
                endcase
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile_riscv.sv
// 2-read 1-write register file; x0 reads as zero, same-cycle write bypasses to reads.
module regfile_riscv
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [NREG-1:0][XLEN-1:0] r_mem;

    // Storage: writes to x0 are dropped so entry 0 stays zero from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_we && i_wa != '0) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : ((i_we && i_wa == i_ra1) ? i_wd : r_mem[i_ra1]);
    assign o_rd2 = (i_ra2 == '0) ? '0 : ((i_we && i_wa == i_ra2) ? i_wd : r_mem[i_ra2]);

endmodule

// File: rtl/alu_issue_riscv.sv
// Issue stage in front of the ALU: decode, register read, busy-bit scoreboard,
// and a single-entry operand register handed to the ALU.
module alu_issue_riscv
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int SEL_W = 4,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rs1_val,
    output logic [XLEN-1:0]  rs2_val,
    output logic [SEL_W-1:0] alu_sel,
    output logic [AW-1:0]    rd_addr,
    output logic             illegal
);

    ostate_t          r_state, w_state_nxt;
    logic [NREG-1:0]  r_busy, w_busy_nxt, w_busy_eff, w_wb_clr;
    logic [XLEN-1:0]  r_rs1, r_rs2;
    logic [SEL_W-1:0] r_sel;
    logic [AW-1:0]    r_rd;
    logic             r_illegal;

    dec_t             w_dec;
    logic [AW-1:0]    w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]  w_rf1, w_rf2, w_imm;
    logic             w_hazard, w_acc, w_acc_ok, w_acc_bad;

    assign w_dec = decode_instr(instr);
    assign w_rs1 = instr[19:15];
    assign w_rs2 = instr[24:20];
    assign w_rd  = instr[11:7];
    assign w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};

    regfile_riscv #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_we  (wb_en),
        .i_wa  (wb_addr),
        .i_wd  (wb_data),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rf1),
        .o_rd2 (w_rf2)
    );

    // A writeback landing this cycle hides its busy bit; the bypass supplies the data.
    assign w_wb_clr   = {{(NREG-1){1'b0}}, wb_en} << wb_addr;
    assign w_busy_eff = r_busy & ~w_wb_clr;
    assign w_hazard   = w_busy_eff[w_rs1] | (w_dec.is_r & w_busy_eff[w_rs2]) | w_busy_eff[w_rd];

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = (!out_valid || out_ready) && !w_hazard;
    assign w_acc     = in_valid && in_ready;
    assign w_acc_ok  = w_acc && w_dec.legal;
    assign w_acc_bad = w_acc && !w_dec.legal;

    // Output-slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Output-slot next state: only a legal accept fills the slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_acc_ok) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_acc_ok) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Operand bundle: loads on legal accept, otherwise holds (stable while stalled).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_sel <= '0;
            r_rd  <= '0;
        end else if (w_acc_ok) begin
            r_rs1 <= w_rf1;
            r_rs2 <= w_dec.is_r ? w_rf2 : w_imm;
            r_sel <= w_dec.sel;
            r_rd  <= w_rd;
        end
    end

    // Illegal flag pulses the cycle after a dropped instruction is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_illegal <= 1'b0;
        else     r_illegal <= w_acc_bad;
    end

    // Scoreboard next value: clear on writeback first, so a same-cycle set wins.
    always_comb begin
        w_busy_nxt = r_busy & ~w_wb_clr;
        if (w_acc_ok && w_rd != '0) w_busy_nxt[w_rd] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign rs1_val = r_rs1;
    assign rs2_val = r_rs2;
    assign alu_sel = r_sel;
    assign rd_addr = r_rd;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_riscv.sv
// Directed table-driven bench for the ALU issue stage plus a hand-written reset sequence.
module tb_alu_issue_riscv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rs1_val, rs2_val;
    logic [3:0]  alu_sel;
    logic [4:0]  rd_addr;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_riscv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .alu_sel   (alu_sel),
        .rd_addr   (rd_addr),
        .illegal   (illegal)
    );

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        in_valid;
        logic [31:0] instr;
        logic        out_ready;
        logic        e_ready;
        logic        e_ovld;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [3:0]  e_sel;
        logic [4:0]  e_rd;
        logic        e_ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic iv,
                                logic [31:0] ins, logic ordy, logic erdy, logic eov,
                                logic [31:0] ers1, logic [31:0] ers2, logic [3:0] esel,
                                logic [4:0] erd, logic eill);
        vec_t v;
        v.wb_en = we; v.wb_addr = wa; v.wb_data = wd; v.in_valid = iv; v.instr = ins;
        v.out_ready = ordy; v.e_ready = erdy; v.e_ovld = eov; v.e_rs1 = ers1;
        v.e_rs2 = ers2; v.e_sel = esel; v.e_rd = erd; v.e_ill = eill;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    initial begin
        // wb  wa  wd  iv  instr        ordy | rdy ov  rs1  rs2          sel    rd  ill
        tbl.push_back(mk(0, 0, 0,  1, 32'h00500093, 1,  1, 1, 0, 5,            4'h0, 1, 0)); // ADDI x1,x0,5
        tbl.push_back(mk(1, 2, 7,  0, 32'h0,        1,  1, 0, 0, 0,            4'h0, 0, 0)); // wb x2=7, drain
        tbl.push_back(mk(1, 3, 3,  0, 32'h0,        1,  1, 0, 0, 0,            4'h0, 0, 0)); // wb x3=3
        tbl.push_back(mk(0, 0, 0,  1, 32'h40310233, 1,  1, 1, 7, 3,            4'h8, 4, 0)); // SUB x4,x2,x3
        tbl.push_back(mk(1, 1, 11, 1, 32'h00500093, 1,  1, 1, 0, 5,            4'h0, 1, 0)); // ADDI x1 while wb x1: set wins
        tbl.push_back(mk(0, 0, 0,  1, 32'h001082B3, 1,  0, 0, 0, 0,            4'h0, 0, 0)); // ADD x5,x1,x1 stalls
        tbl.push_back(mk(1, 1, 9,  1, 32'h001082B3, 1,  1, 1, 9, 9,            4'h0, 5, 0)); // wb x1=9 bypass
        tbl.push_back(mk(0, 0, 0,  1, 32'h0010E333, 0,  0, 1, 9, 9,            4'h0, 5, 0)); // held 1
        tbl.push_back(mk(0, 0, 0,  1, 32'h0010E333, 0,  0, 1, 9, 9,            4'h0, 5, 0)); // held 2
        tbl.push_back(mk(0, 0, 0,  1, 32'h0010E333, 0,  0, 1, 9, 9,            4'h0, 5, 0)); // held 3
        tbl.push_back(mk(0, 0, 0,  1, 32'h0010E333, 1,  1, 1, 9, 9,            4'h6, 6, 0)); // OR x6 back-to-back
        tbl.push_back(mk(0, 0, 0,  1, 32'hFFF0F393, 1,  1, 1, 9, 32'hFFFFFFFF, 4'h7, 7, 0)); // ANDI x7,x1,-1
        tbl.push_back(mk(0, 0, 0,  1, 32'h0000006F, 1,  1, 0, 0, 0,            4'h0, 0, 1)); // JAL illegal
        tbl.push_back(mk(0, 0, 0,  0, 32'h0,        1,  1, 0, 0, 0,            4'h0, 0, 0)); // pulse ends
        tbl.push_back(mk(0, 0, 0,  1, 32'h00100013, 1,  1, 1, 0, 1,            4'h0, 0, 0)); // ADDI x0,x0,1
        tbl.push_back(mk(0, 0, 0,  1, 32'h00006413, 1,  1, 1, 0, 0,            4'h6, 8, 0)); // ORI x8,x0,0: x0 not busy
        tbl.push_back(mk(0, 0, 0,  1, 32'h000204B3, 1,  0, 0, 0, 0,            4'h0, 0, 0)); // ADD x9,x4,x0: x4 busy
        tbl.push_back(mk(0, 0, 0,  1, 32'h02000533, 1,  1, 0, 0, 0,            4'h0, 0, 1)); // MUL illegal

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", -1, {31'b0, out_valid}, 0);
        chk("rst_rs1",       -1, rs1_val, 0);
        chk("rst_rs2",       -1, rs2_val, 0);
        chk("rst_sel",       -1, {28'b0, alu_sel}, 0);
        chk("rst_rd",        -1, {27'b0, rd_addr}, 0);
        chk("rst_illegal",   -1, {31'b0, illegal}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            wb_en = tbl[k].wb_en; wb_addr = tbl[k].wb_addr; wb_data = tbl[k].wb_data;
            in_valid = tbl[k].in_valid; instr = tbl[k].instr; out_ready = tbl[k].out_ready;
            #1;
            chk("in_ready", k, {31'b0, in_ready}, {31'b0, tbl[k].e_ready});
            @(posedge clk);
            #1;
            chk("out_valid", k, {31'b0, out_valid}, {31'b0, tbl[k].e_ovld});
            chk("illegal",   k, {31'b0, illegal},   {31'b0, tbl[k].e_ill});
            if (tbl[k].e_ovld) begin
                chk("rs1_val", k, rs1_val, tbl[k].e_rs1);
                chk("rs2_val", k, rs2_val, tbl[k].e_rs2);
                chk("alu_sel", k, {28'b0, alu_sel}, {28'b0, tbl[k].e_sel});
                chk("rd_addr", k, {27'b0, rd_addr}, {27'b0, tbl[k].e_rd});
            end
        end

        // Mid-operation reset: x4 written, then busy again with a full, stalled bundle
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        @(negedge clk);
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h00100213; out_ready = 1'b0; // ADDI x4,x0,1
        #1;
        chk("pre_rst_ready", 100, {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 100, {31'b0, out_valid}, 1);
        chk("pre_rst_rd",    100, {27'b0, rd_addr}, 4);
        @(negedge clk);
        in_valid = 1'b0; instr = '0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 101, {31'b0, out_valid}, 0);
        chk("async_rst_rd",    101, {27'b0, rd_addr}, 0);
        chk("async_rst_rs2",   101, rs2_val, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; instr = 32'h000204B3; out_ready = 1'b1; // ADD x9,x4,x0
        #1;
        chk("post_rst_ready", 102, {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 102, {31'b0, out_valid}, 1);
        chk("post_rst_x4",    102, rs1_val, 0);
        chk("post_rst_rd",    102, {27'b0, rd_addr}, 9);
        @(negedge clk);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
